// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N-to-1 word multiplexer built as a binary tree of 2:1 stages.
// Stage k resolves sel[k]. A register bank can follow any stage (PIPE_MASK[k]=1).
// Each bank carries the data, a valid bit and the select bits that are still
// needed downstream, so the live sel input only matters in the request cycle.
// With PIPE_MASK all zero the block is purely combinational, and stall, flush
// and reset_n have no effect.

module mux_tree_pipe #(
    parameter int WIDTH      = 64,
    parameter int NUM_IN     = 32,
    parameter logic [$clog2(NUM_IN)-1:0] PIPE_MASK = 5'b00100,
    localparam int SEL_W     = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out
);

    for (genvar k = 0; k < SEL_W; k++) begin : g_stage
        // Number of candidate words this stage leaves for the next one.
        localparam int NO = NUM_IN >> (k + 1);

        logic [2*NO*WIDTH-1:0] d_in_s;
        logic [SEL_W-1:0]      sel_in_s;
        logic                  vld_in_s;
        logic [NO*WIDTH-1:0]   mux_s;
        logic [NO*WIDTH-1:0]   d_out_s;
        logic [SEL_W-1:0]      sel_out_s;
        logic                  vld_out_s;

        // The first stage takes the ports; later stages take the previous stage.
        if (k == 0) begin : g_src
            assign d_in_s   = in;
            assign sel_in_s = sel;
            assign vld_in_s = in_valid;
        end else begin : g_src
            assign d_in_s   = g_stage[k-1].d_out_s;
            assign sel_in_s = g_stage[k-1].sel_out_s;
            assign vld_in_s = g_stage[k-1].vld_out_s;
        end

        // Pairwise 2:1 selection: pair j picks element 2j+1 when sel[k] is set.
        always_comb begin
            mux_s = '0;
            for (int j = 0; j < NO; j++) begin
                if (sel_in_s[k]) begin
                    mux_s[j*WIDTH +: WIDTH] = d_in_s[(2*j+1)*WIDTH +: WIDTH];
                end else begin
                    mux_s[j*WIDTH +: WIDTH] = d_in_s[(2*j)*WIDTH +: WIDTH];
                end
            end
        end

        if (PIPE_MASK[k]) begin : g_reg
            logic [NO*WIDTH-1:0] data_d;
            logic [NO*WIDTH-1:0] data_q;
            logic [SEL_W-1:0]    sel_d;
            logic [SEL_W-1:0]    sel_q;
            logic                vld_d;
            logic                vld_q;

            // Next state of the bank: flush kills valid, stall holds, else load.
            // Data loads regardless of valid; bubbles carry don't-care words.
            always_comb begin
                data_d = data_q;
                sel_d  = sel_q;
                vld_d  = vld_q;
                if (flush) begin
                    vld_d = 1'b0;
                end else if (stall) begin
                    vld_d = vld_q;
                end else begin
                    data_d = mux_s;
                    sel_d  = sel_in_s;
                    vld_d  = vld_in_s;
                end
            end

            // Bank registers with synchronous active-low reset clearing everything.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    data_q <= '0;
                    sel_q  <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    data_q <= data_d;
                    sel_q  <= sel_d;
                    vld_q  <= vld_d;
                end
            end

            assign d_out_s   = data_q;
            assign sel_out_s = sel_q;
            assign vld_out_s = vld_q;
        end else begin : g_pass
            assign d_out_s   = mux_s;
            assign sel_out_s = sel_in_s;
            assign vld_out_s = vld_in_s;
        end
    end

    assign out       = g_stage[SEL_W-1].d_out_s;
    assign out_valid = g_stage[SEL_W-1].vld_out_s;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: four instances (mask 00100, 11111, 10101, and a
// combinational 4x8 variant). Stimulus pushes expected word plus due cycle
// into a per-instance queue; a negedge monitor pops and compares whenever an
// instance raises out_valid, and flags late or spurious results.

module tb_mux_tree_pipe;

    typedef struct {
        logic [63:0] val;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb [4][$];

    logic [2047:0] in_w;
    logic [4:0]    sel5;

    logic a_rst_n, a_iv, a_stall, a_flush, a_ov;
    logic [63:0] a_out;
    logic b_rst_n, b_iv, b_stall, b_flush, b_ov;
    logic [63:0] b_out;
    logic c_rst_n, c_iv, c_stall, c_flush, c_ov;
    logic [63:0] c_out;
    logic d_rst_n, d_iv, d_stall, d_flush, d_ov;
    logic [1:0]  d_sel;
    logic [31:0] d_in;
    logic [7:0]  d_out;

    always #5 clk = ~clk;

    // Cycle counter used for due-cycle bookkeeping.
    always @(posedge clk) cyc <= cyc + 1;

    mux_tree_pipe #(.WIDTH(64), .NUM_IN(32), .PIPE_MASK(5'b00100)) u_a (
        .clk(clk), .reset_n(a_rst_n), .in_valid(a_iv), .sel(sel5), .in(in_w),
        .stall(a_stall), .flush(a_flush), .out_valid(a_ov), .out(a_out));

    mux_tree_pipe #(.WIDTH(64), .NUM_IN(32), .PIPE_MASK(5'b11111)) u_b (
        .clk(clk), .reset_n(b_rst_n), .in_valid(b_iv), .sel(sel5), .in(in_w),
        .stall(b_stall), .flush(b_flush), .out_valid(b_ov), .out(b_out));

    mux_tree_pipe #(.WIDTH(64), .NUM_IN(32), .PIPE_MASK(5'b10101)) u_c (
        .clk(clk), .reset_n(c_rst_n), .in_valid(c_iv), .sel(sel5), .in(in_w),
        .stall(c_stall), .flush(c_flush), .out_valid(c_ov), .out(c_out));

    mux_tree_pipe #(.WIDTH(8), .NUM_IN(4), .PIPE_MASK(2'b00)) u_d (
        .clk(clk), .reset_n(d_rst_n), .in_valid(d_iv), .sel(d_sel), .in(d_in),
        .stall(d_stall), .flush(d_flush), .out_valid(d_ov), .out(d_out));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input string nm, input logic ov, input logic [63:0] o);
        exp_t e;
        if (ov === 1'b1) begin
            if (sb[id].size() == 0) begin
                chk({nm, "_spurious_valid"}, 64'(ov), 64'd0);
            end else begin
                e = sb[id].pop_front();
                chk({nm, "_data"}, o, e.val);
                chk({nm, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end else if (sb[id].size() != 0 && sb[id][0].due < cyc) begin
            e = sb[id].pop_front();
            chk({nm, "_missing_valid"}, 64'(ov), 64'd1);
        end
    endtask

    // Monitor: compare every presented result against the scoreboard heads.
    always @(negedge clk) begin
        mon(0, "A", a_ov, a_out);
        mon(1, "B", b_ov, b_out);
        mon(2, "C", c_ov, c_out);
        mon(3, "D", d_ov, 64'(d_out));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] word(input int i);
        return 64'h1000_0000_0000_0000 + 64'(i);
    endfunction

    task automatic load_words;
        for (int i = 0; i < 32; i++) in_w[i*64 +: 64] = word(i);
    endtask

    initial begin
        int bv [3];
        logic [7:0] dexp [4];
        logic [1:0] dv_sel [6];
        logic       dv_iv  [6];
        logic [2:0] dv_ctl [6];

        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0; d_rst_n = 1'b0;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0; d_iv = 1'b0;
        a_stall = 1'b0; b_stall = 1'b0; c_stall = 1'b0; d_stall = 1'b0;
        a_flush = 1'b0; b_flush = 1'b0; c_flush = 1'b0; d_flush = 1'b0;
        sel5 = 5'd0; d_sel = 2'd0;
        d_in = 32'hDDCC_BBAA;
        load_words();

        // Reset held for two edges.
        tick();
        tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        chk("A_reset_valid", 64'(a_ov), 64'd0);
        chk("A_reset_out", a_out, 64'd0);
        chk("B_reset_valid", 64'(b_ov), 64'd0);
        chk("B_reset_out", b_out, 64'd0);
        chk("C_reset_valid", 64'(c_ov), 64'd0);
        chk("C_reset_out", c_out, 64'd0);

        // Default mask: full sweep, one cycle latency, back-to-back.
        for (int s = 0; s < 32; s++) begin
            a_iv = 1'b1;
            sel5 = 5'(s);
            sb[0].push_back('{val: word(s), due: cyc + 1});
            tick();
        end
        a_iv = 1'b0;
        repeat (3) tick();

        // Fully pipelined: burst of three, input zeroed after capture.
        bv[0] = 5; bv[1] = 17; bv[2] = 31;
        for (int i = 0; i < 3; i++) begin
            b_iv = 1'b1;
            sel5 = 5'(bv[i]);
            sb[1].push_back('{val: word(bv[i]), due: cyc + 5});
            tick();
        end
        b_iv = 1'b0;
        in_w = '0;
        tick();
        load_words();
        b_iv = 1'b1;
        sel5 = 5'd6;
        sb[1].push_back('{val: word(6), due: cyc + 5});
        tick();
        b_iv = 1'b0;
        in_w = '0;
        repeat (6) tick();
        load_words();

        // Mask 10101: stall four cycles after issue; request during stall is ignored.
        c_iv = 1'b1;
        sel5 = 5'd9;
        sb[2].push_back('{val: word(9), due: cyc + 7});
        tick();
        c_iv = 1'b1;
        sel5 = 5'd20;
        c_stall = 1'b1;
        tick();
        c_iv = 1'b0;
        repeat (3) tick();
        c_stall = 1'b0;
        repeat (6) tick();

        // Flush together with stall kills two in-flight requests.
        b_iv = 1'b1;
        sel5 = 5'd3;
        tick();
        sel5 = 5'd4;
        tick();
        b_iv = 1'b0;
        b_flush = 1'b1;
        b_stall = 1'b1;
        tick();
        b_flush = 1'b0;
        b_stall = 1'b0;
        repeat (6) tick();
        b_iv = 1'b1;
        sel5 = 5'd2;
        sb[1].push_back('{val: word(2), due: cyc + 5});
        tick();
        b_iv = 1'b0;
        repeat (6) tick();

        // Reset mid-burst: nothing stale emerges, then a fresh request works.
        for (int v = 1; v <= 4; v++) begin
            b_iv = 1'b1;
            sel5 = 5'(v);
            tick();
        end
        b_rst_n = 1'b0;
        sel5 = 5'd5;
        tick();
        b_rst_n = 1'b1;
        b_iv = 1'b0;
        chk("B_midreset_valid", 64'(b_ov), 64'd0);
        chk("B_midreset_out", b_out, 64'd0);
        repeat (6) tick();
        b_iv = 1'b1;
        sel5 = 5'd7;
        sb[1].push_back('{val: word(7), due: cyc + 5});
        tick();
        b_iv = 1'b0;
        repeat (6) tick();

        // Combinational variant: out follows sel in the same cycle; controls ignored.
        dexp[0] = 8'hAA; dexp[1] = 8'hBB; dexp[2] = 8'hCC; dexp[3] = 8'hDD;
        dv_sel[0] = 2'd0; dv_iv[0] = 1'b1; dv_ctl[0] = 3'b001;
        dv_sel[1] = 2'd3; dv_iv[1] = 1'b1; dv_ctl[1] = 3'b101;
        dv_sel[2] = 2'd1; dv_iv[2] = 1'b1; dv_ctl[2] = 3'b010;
        dv_sel[3] = 2'd2; dv_iv[3] = 1'b1; dv_ctl[3] = 3'b110;
        dv_sel[4] = 2'd3; dv_iv[4] = 1'b0; dv_ctl[4] = 3'b111;
        dv_sel[5] = 2'd0; dv_iv[5] = 1'b1; dv_ctl[5] = 3'b000;
        for (int i = 0; i < 6; i++) begin
            d_sel   = dv_sel[i];
            d_iv    = dv_iv[i];
            d_stall = dv_ctl[i][2];
            d_flush = dv_ctl[i][1];
            d_rst_n = dv_ctl[i][0];
            if (dv_iv[i]) begin
                sb[3].push_back('{val: 64'(dexp[dv_sel[i]]), due: cyc});
            end else begin
                #1;
                chk("D_out_novalid", 64'(d_out), 64'(dexp[dv_sel[i]]));
                chk("D_valid_low", 64'(d_ov), 64'd0);
            end
            tick();
        end
        d_iv = 1'b0;
        repeat (3) tick();

        chk("A_leftover", 64'(sb[0].size()), 64'd0);
        chk("B_leftover", 64'(sb[1].size()), 64'd0);
        chk("C_leftover", 64'(sb[2].size()), 64'd0);
        chk("D_leftover", 64'(sb[3].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, optionally pipelined N-to-1 multiplexer tree of WIDTH-bit words, built as log2(NUM_IN) stages of 2:1 selection with per-stage pipeline registers chosen by mask. It serves as the register-file read-port mux and the forwarding/result-select mux in the datapath where 64-bit operands and timing closure require splitting the select tree across cycles. A valid bit, stall (hold) and flush travel with the data so the block drops into a stalled pipeline.

## Interface
- WIDTH, 64, data word width in bits (1..128)
- NUM_IN, 32, number of input words; power of two, 2..64
- SEL_W, $clog2(NUM_IN), select width; derived, not overridden
- PIPE_MASK, 5'b00100, SEL_W bits; bit k=1 places a register bank after stage k (stage k resolves sel[k])
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  a selection request is presented this cycle
- sel  input  SEL_W  index of the word to select; sel[k] consumed at stage k
- in  input  NUM_IN*WIDTH  word i at in[i*WIDTH +: WIDTH]
- stall  input  1  hold every pipeline register (data, valid, carried sel bits)
- flush  input  1  clear every in-flight valid bit
- out_valid  output  1  out carries a completed selection
- out  output  WIDTH  selected word

## Operation
- Stage k (0..SEL_W-1) halves the candidate set: pair j chooses between elements 2j and 2j+1 of the previous stage using sel[k] (0 picks 2j).
- If PIPE_MASK[k]=1, stage k outputs, a valid bit and the still-unconsumed bits sel[SEL_W-1:k+1] are registered; downstream stages use the registered sel bits, never the live sel input.
- in and sel need only be stable in the cycle in_valid is asserted; the first register bank captures everything needed.
- Register bank update, in priority order each edge:
  - reset_n=0: all valid bits 0, all data and carried sel bits 0.
  - flush=1: all valid bits 0; data and sel registers may load or hold (don't care).
  - stall=1: all registers hold.
  - else: every bank loads its upstream value; valid of bank 0 loads in_valid.
- Data registers load regardless of valid (bubbles carry garbage); out is qualified only by out_valid.
- PIPE_MASK=0: fully combinational; out_valid=in_valid, out=in word sel; stall, flush and reset have no effect.
- No backpressure output; the enclosing pipeline drives stall.

## Timing
- Latency L = popcount(PIPE_MASK) cycles from in_valid/sel/in sampling to out_valid/out. Default L=1.
- Throughput one selection per non-stalled cycle; back-to-back requests each emerge exactly L unstalled cycles later, in order.
- Reset values: out_valid=0, out=0 (when L≥1 and PIPE_MASK[SEL_W-1]=1; otherwise out is combinational from the last register bank, which resets to 0).
- Stall for S cycles: out_valid/out frozen for S cycles; input presented during stall is ignored (not captured).
- Simultaneous stall and flush: flush wins; valids cleared on that edge.
- Flush and in_valid same cycle: request dropped; out_valid stays 0 for next L cycles.
- reset_n mid-operation: all in-flight requests lost; out_valid=0 from the next edge until a new request completes L cycles after reset_n rises.
- Combinational path per pipeline segment: at most (stages in segment) 2:1 mux levels.

## Test plan
- Default params, reset_n low 2 cycles, then in word i = 64'h1000_0000_0000_0000+i, sweep sel 0..31 with in_valid=1 every cycle -> out_valid high from cycle 1, out = 64'h1000..00+sel of the request issued 1 cycle earlier, 32 consecutive results.
- PIPE_MASK=5'b11111, 3-request burst sel=5,17,31 -> each appears exactly 5 cycles after issue, in order, out_valid pulses 3 consecutive cycles; in changed to all-zero the cycle after each issue does not corrupt results.
- PIPE_MASK=5'b10101, issue sel=9, stall high 4 cycles starting 1 cycle later -> out_valid/out for sel=9 appear at cycle 3+4=7; request offered during stall never appears.
- Issue sel=3 and sel=4 back-to-back, assert flush together with stall the following cycle -> out_valid never asserts for either; next request sel=2 completes normally at L cycles.
- Mid-burst reset_n low 1 cycle (PIPE_MASK=5'b11111) -> out_valid=0 and out=0 the cycle after, no stale result emerges over the next 5 cycles.
- PIPE_MASK=0, NUM_IN=4, WIDTH=8, in={8'hDD,8'hCC,8'hBB,8'hAA} -> out follows sel same cycle (0->AA,3->DD); stall/flush/reset_n toggling leaves out and out_valid=in_valid unchanged.
